// File: rtl/fp_mul_booth_seq_pkg.sv
// Shared definitions for the iterative radix-4 Booth significand multiplier.
// Holds the step-count derivation, the FSM state type and the Booth digit encoding.
package fp_mul_pkg;
  localparam int FRAC_W_DEF = 23;
  localparam int TAG_W_DEF  = 14;

  // One radix-4 digit per two multiplier bits; the extra guard keeps the top digit non-negative.
  function automatic int booth_steps(input int n);
    return (n + 2) / 2;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_PM   = 3'd1,
    BD_P2M  = 3'd2,
    BD_NM   = 3'd3,
    BD_N2M  = 3'd4
  } booth_dig_t;

  function automatic booth_dig_t booth_decode(input logic [2:0] b);
    case (b)
      3'b001, 3'b010: return BD_PM;
      3'b011:         return BD_P2M;
      3'b100:         return BD_N2M;
      3'b101, 3'b110: return BD_NM;
      default:        return BD_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/product handshake bundle between the FP multiplier front end and normalise.
interface fp_mul_booth_seq_if
  import fp_mul_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  localparam int N = FRAC_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              hid_x;
  logic [FRAC_W-1:0] frc_X;
  logic              hid_y;
  logic [FRAC_W-1:0] frc_Y;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [2*N-1:0]    frc_Z_full;
  logic              norm_n;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, hid_x, frc_X, hid_y, frc_Y, tag_in, out_ready,
    input  in_ready, out_valid, frc_Z_full, norm_n, tag_out
  );

  modport slave (
    input  in_valid, hid_x, frc_X, hid_y, frc_Y, tag_in, out_ready,
    output in_ready, out_valid, frc_Z_full, norm_n, tag_out
  );
endinterface

// File: rtl/fp_mul_booth_seq_digit.sv
// Radix-4 Booth recoder: three multiplier bits select 0, +-M or +-2M as an N+3 bit addend.
module booth_r4_digit
  import fp_mul_pkg::*;
#(
  parameter int N = FRAC_W_DEF + 1
) (
  input  logic [2:0]          bits,
  input  logic [N-1:0]        m,
  output logic signed [N+2:0] addend
);
  logic [N+2:0] m1, m2;

  assign m1 = {3'b000, m};
  assign m2 = {2'b00, m, 1'b0};

  always_comb begin
    addend = '0;
    case (booth_decode(bits))
      BD_PM:   addend = m1;
      BD_P2M:  addend = m2;
      BD_NM:   addend = -m1;
      BD_N2M:  addend = -m2;
      default: addend = '0;
    endcase
  end
endmodule

// File: rtl/fp_mul_booth_seq.sv
// Multi-cycle radix-4 Booth significand multiplier, one digit per clock, valid/ready on both sides.
// The raw 2N-bit product and its MSB (norm_n) feed the normalise/round stage.
module fp_mul_booth_seq
  import fp_mul_pkg::*;
#(
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  fp_mul_booth_seq_if.slave bus
);
  localparam int N     = FRAC_W + 1;
  localparam int STEPS = booth_steps(N);
  localparam int QW    = 2 * STEPS;
  localparam int AW    = N + 3;
  localparam int CW    = AW + QW;
  localparam int CNT_W = $clog2(STEPS);

  mul_state_t        state, state_nx;
  logic [N-1:0]      m_q;
  logic [AW-1:0]     acc_q;
  logic [QW-1:0]     q_q;
  logic              qm1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              zero_q;
  logic [2*N-1:0]    res_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept, last;
  logic signed [AW-1:0] addend;
  logic [AW-1:0]     sum;
  logic [CW-1:0]     comb_nx;
  logic [N-1:0]      x_sig, y_sig;

  assign x_sig  = {bus.hid_x, bus.frc_X};
  assign y_sig  = {bus.hid_y, bus.frc_Y};
  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == BUSY) && (zero_q || (cnt_q == CNT_W'(STEPS - 1)));

  booth_r4_digit #(.N(N)) u_digit (
    .bits   ({q_q[1:0], qm1_q}),
    .m      (m_q),
    .addend (addend)
  );

  // Add the digit to the upper half, then arithmetic-shift {acc,Q} right by two.
  assign sum     = acc_q + $unsigned(addend);
  assign comb_nx = {sum[AW-1], sum[AW-1], sum, q_q[QW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = BUSY;
      BUSY:    if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      res_q  <= '0;
      tag_q  <= '0;
    end else if (accept) begin
      m_q    <= x_sig;
      acc_q  <= '0;
      q_q    <= {{(QW-N){1'b0}}, y_sig};
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      zero_q <= EARLY_ZERO && ((x_sig == '0) || (y_sig == '0));
      tag_q  <= bus.tag_in;
    end else if (state == BUSY) begin
      acc_q <= comb_nx[CW-1:QW];
      q_q   <= comb_nx[QW-1:0];
      qm1_q <= q_q[1];
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) res_q <= zero_q ? '0 : comb_nx[2*N-1:0];
    end
  end

  assign bus.frc_Z_full = res_q;
  assign bus.norm_n     = res_q[2*N-1];
  assign bus.tag_out    = tag_q;
endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Table-driven bench with a product scoreboard, plus hand sequences for early-zero, back-pressure and reset.
module tb_fp_mul_booth_seq;
  import fp_mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_booth_seq_if #(.FRAC_W(23), .TAG_W(14)) b0 ();
  fp_mul_booth_seq_if #(.FRAC_W(23), .TAG_W(14)) b1 ();

  fp_mul_booth_seq #(.FRAC_W(23), .TAG_W(14), .EARLY_ZERO(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  fp_mul_booth_seq #(.FRAC_W(23), .TAG_W(14), .EARLY_ZERO(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  typedef struct {
    logic        hx;
    logic [22:0] fx;
    logic        hy;
    logic [22:0] fy;
    logic [13:0] tag;
    logic [47:0] prod;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [47:0] prod;
    logic [13:0] tag;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[10];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int          lat;
    logic [47:0] held;
    sb_t         e;
    @(negedge clk);
    b0.hid_x = v.hx; b0.frc_X = v.fx; b0.hid_y = v.hy; b0.frc_Y = v.fy;
    b0.tag_in = v.tag; b0.in_valid = 1'b1; b0.out_ready = 1'b0;
    chk("in_ready_idle", 64'(b0.in_ready), 64'd1);
    @(posedge clk);
    e.prod = v.prod; e.tag = v.tag;
    sbq.push_back(e);
    lat = 1;
    @(negedge clk);
    // Scramble inputs after accept: the result must come from the captured operands.
    b0.in_valid = 1'b0; b0.hid_x = ~v.hx; b0.frc_X = ~v.fx;
    b0.hid_y = ~v.hy; b0.frc_Y = ~v.fy; b0.tag_in = ~v.tag;
    while (!b0.out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(v.lat));
    held = b0.frc_Z_full;
    for (int h = 0; h < v.hold; h++) begin
      b0.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 64'(b0.out_valid), 64'd1);
      chk("hold_data", 64'(b0.frc_Z_full), 64'(held));
      chk("hold_tag", 64'(b0.tag_out), 64'(v.tag));
      chk("done_in_ready", 64'(b0.in_ready), 64'd0);
    end
    b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    if (sbq.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sbq.pop_front();
      chk("frc_Z_full", 64'(b0.frc_Z_full), 64'(e.prod));
      chk("norm_n", 64'(b0.norm_n), 64'(e.prod[47]));
      chk("tag_out", 64'(b0.tag_out), 64'(e.tag));
    end
    @(posedge clk); @(negedge clk);
    b0.out_ready = 1'b0;
    chk("out_valid_drop", 64'(b0.out_valid), 64'd0);
    chk("in_ready_back", 64'(b0.in_ready), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    b0.in_valid = 0; b0.out_ready = 0; b0.hid_x = 0; b0.frc_X = 0;
    b0.hid_y = 0; b0.frc_Y = 0; b0.tag_in = 0;
    b1.in_valid = 0; b1.out_ready = 0; b1.hid_x = 0; b1.frc_X = 0;
    b1.hid_y = 0; b1.frc_Y = 0; b1.tag_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_frc", 64'(b0.frc_Z_full), 64'd0);
    chk("rst_norm", 64'(b0.norm_n), 64'd0);
    chk("rst_tag", 64'(b0.tag_out), 64'd0);
    rst_n = 1'b1;

    vecs[0] = '{1'b1, 23'h000000, 1'b1, 23'h000000, 14'h0001, 48'h400000000000, 14, 0};
    vecs[1] = '{1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 14'h2AAA, 48'hFFFFFE000001, 14, 0};
    vecs[2] = '{1'b0, 23'h000001, 1'b1, 23'h000000, 14'h0155, 48'h000000800000, 14, 0};
    vecs[3] = '{1'b0, 23'h000000, 1'b1, 23'h123456, 14'h3FFF, 48'h0, 2, 0};
    vecs[4] = '{1'b1, 23'h2DF854, 1'b0, 23'h000000, 14'h0F0F, 48'h0, 2, 1};
    vecs[5] = '{1'b1, 23'h2DF854, 1'b1, 23'h490FDB, 14'h1ABC,
                48'h00ADF854 * 48'h00C90FDB, 14, 5};
    for (int i = 6; i < 10; i++) begin
      vecs[i].hx = 1'b1; vecs[i].fx = 23'($urandom);
      vecs[i].hy = 1'($urandom); vecs[i].fy = 23'($urandom) | 23'h1;
      vecs[i].tag = 14'($urandom);
      vecs[i].prod = 48'({vecs[i].hx, vecs[i].fx}) * 48'({vecs[i].hy, vecs[i].fy});
      vecs[i].lat = 14; vecs[i].hold = i - 6;
    end
    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Zero operand without the early-out takes the full iteration.
    @(negedge clk);
    b1.hid_x = 0; b1.frc_X = 0; b1.hid_y = 1; b1.frc_Y = 23'h123456;
    b1.tag_in = 14'h00AA; b1.in_valid = 1; b1.out_ready = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    b1.in_valid = 0;
    while (!b1.out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("nz_latency", 64'(lat), 64'd14);
    chk("nz_frc", 64'(b1.frc_Z_full), 64'd0);
    chk("nz_norm", 64'(b1.norm_n), 64'd0);
    chk("nz_tag", 64'(b1.tag_out), 64'h00AA);
    b1.out_ready = 1;
    @(posedge clk); @(negedge clk);
    b1.out_ready = 0;
    chk("nz_drop", 64'(b1.out_valid), 64'd0);

    // Reset partway through BUSY discards the op and clears all outputs immediately.
    @(negedge clk);
    b0.hid_x = 1; b0.frc_X = 0; b0.hid_y = 1; b0.frc_Y = 0;
    b0.tag_in = 14'h0777; b0.in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    b0.in_valid = 0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("arst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("arst_frc", 64'(b0.frc_Z_full), 64'd0);
    chk("arst_norm", 64'(b0.norm_n), 64'd0);
    chk("arst_tag", 64'(b0.tag_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
